// File: rtl/perm_switch_net_pkg.sv
// perm_switch_net_pkg: shared types, widths and lane-pairing helper for the permutation network
package perm_switch_net_pkg;
    localparam int SW_DATA_WIDTH = 16;
    localparam int SW_STRIDE_W = 4;
    typedef enum logic [1:0] {
        SW_PASS    = 2'd0,
        SW_STRIDE  = 2'd1,
        SW_MASK    = 2'd2,
        SW_REVERSE = 2'd3
    } sw_mode_e;
    function automatic int sw_pair_lo(input int p, input int s);
        return ((p >> s) << (s + 1)) | (p & ((1 << s) - 1));
    endfunction
endpackage

// File: rtl/perm_switch_stage.sv
// perm_switch_stage: one registered column of 2x2 exchange cells pairing lanes 2^STAGE apart
module perm_switch_stage
    import perm_switch_net_pkg::*;
#(
    parameter int STAGE = 0,
    parameter int N_PORTS = 8,
    parameter int DATA_WIDTH = SW_DATA_WIDTH,
    localparam int LOG2N = $clog2(N_PORTS),
    localparam int HALF = N_PORTS / 2,
    localparam int SW_IN = 1 + (LOG2N - STAGE) * HALF,
    localparam int SW_OUT = SW_IN - HALF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall_i,
    input  logic                          valid_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0] data_i,
    input  logic [SW_IN-1:0]              side_i,
    output logic                          valid_o,
    output logic [N_PORTS*DATA_WIDTH-1:0] data_o,
    output logic [SW_OUT-1:0]             side_o
);
    // side bits: [0] err, then one ctrl row per remaining stage with this stage's row lowest
    logic [HALF-1:0]               row;
    logic [N_PORTS*DATA_WIDTH-1:0] data_d, data_q;
    logic [SW_OUT-1:0]             side_d, side_q;
    logic                          valid_q;
    assign row = side_i[1 +: HALF];
    for (genvar p = 0; p < HALF; p++) begin : g_cell
        localparam int LO = sw_pair_lo(p, STAGE);
        localparam int HI = LO + (1 << STAGE);
        assign data_d[LO*DATA_WIDTH +: DATA_WIDTH] = row[p] ? data_i[HI*DATA_WIDTH +: DATA_WIDTH]
                                                            : data_i[LO*DATA_WIDTH +: DATA_WIDTH];
        assign data_d[HI*DATA_WIDTH +: DATA_WIDTH] = row[p] ? data_i[LO*DATA_WIDTH +: DATA_WIDTH]
                                                            : data_i[HI*DATA_WIDTH +: DATA_WIDTH];
    end
    if (SW_OUT > 1) begin : g_fwd
        assign side_d = {side_i[SW_IN-1 -: SW_OUT-1], side_i[0]};
    end else begin : g_last
        assign side_d = side_i[0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            side_q  <= '0;
        end else if (!stall_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            side_q  <= side_d;
        end
    end
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign side_o  = side_q;
endmodule

// File: rtl/perm_switch_net.sv
// perm_switch_net: N-lane registered butterfly permutation network; control travels with each vector
module perm_switch_net
    import perm_switch_net_pkg::*;
#(
    parameter int DATA_WIDTH = SW_DATA_WIDTH,
    parameter int N_PORTS = 8,
    parameter int LOG2N = $clog2(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [N_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [1:0]                    in_mode,
    input  logic [SW_STRIDE_W-1:0]        in_stride,
    input  logic [LOG2N*N_PORTS/2-1:0]    in_mask,
    input  logic                          stall,
    output logic                          out_valid,
    output logic [N_PORTS*DATA_WIDTH-1:0] out_data,
    output logic                          out_err
);
    localparam int HALF = N_PORTS / 2;
    localparam int CW = LOG2N * HALF;
    function automatic int side_off(input int s);
        int o = 0;
        for (int k = 0; k < s; k++) o += 1 + (LOG2N - k) * HALF;
        return o;
    endfunction
    localparam int SIDE_TOT = side_off(LOG2N) + 1;
    logic [CW-1:0]                 ctrl_d;
    logic                          err_d;
    logic [CW:0]                   side_d, side_q;
    logic                          in_valid_q;
    logic [N_PORTS*DATA_WIDTH-1:0] in_data_q;
    logic [LOG2N:0]                valid_bus;
    logic [N_PORTS*DATA_WIDTH-1:0] data_bus [LOG2N+1];
    logic [SIDE_TOT-1:0]           side_bus;
    for (genvar s = 0; s < LOG2N; s++) begin : g_dec
        assign ctrl_d[s*HALF +: HALF] =
            (in_mode == SW_REVERSE) ? '1 :
            (in_mode == SW_MASK) ? in_mask[s*HALF +: HALF] :
            (in_mode == SW_STRIDE && in_stride == SW_STRIDE_W'(s)) ? '1 : '0;
    end
    // an out-of-range stride matches no row above, so it already decodes as PASS
    assign err_d  = (in_mode == SW_STRIDE) && (in_stride >= SW_STRIDE_W'(LOG2N));
    assign side_d = {ctrl_d, err_d};
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
            side_q     <= '0;
        end else if (!stall) begin
            in_valid_q <= in_valid;
            in_data_q  <= in_data;
            side_q     <= side_d;
        end
    end
    assign valid_bus[0]         = in_valid_q;
    assign data_bus[0]          = in_data_q;
    assign side_bus[0 +: CW+1]  = side_q;
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam int OFF_I = side_off(s);
        localparam int OFF_O = side_off(s + 1);
        localparam int W_I = 1 + (LOG2N - s) * HALF;
        perm_switch_stage #(
            .STAGE(s),
            .N_PORTS(N_PORTS),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk(clk),
            .rst(rst),
            .stall_i(stall),
            .valid_i(valid_bus[s]),
            .data_i(data_bus[s]),
            .side_i(side_bus[OFF_I +: W_I]),
            .valid_o(valid_bus[s+1]),
            .data_o(data_bus[s+1]),
            .side_o(side_bus[OFF_O +: W_I-HALF])
        );
    end
    assign out_valid = valid_bus[LOG2N];
    assign out_data  = data_bus[LOG2N];
    assign out_err   = side_bus[SIDE_TOT-1];
endmodule

// File: tb/tb_perm_switch_net.sv
// tb_perm_switch_net: directed and randomized checks of perm_switch_net against a lane-array model
module tb_perm_switch_net;
    import perm_switch_net_pkg::*;
    localparam int N = 8;
    localparam int DW = SW_DATA_WIDTH;
    localparam int LOG2N = 3;
    localparam int HALF = N / 2;
    localparam int MW = LOG2N * HALF;
    localparam int W = N * DW;
    typedef struct {
        logic [W-1:0] d;
        logic         e;
        int           left;
    } pend_t;
    logic          clk = 1'b0;
    logic          rst, in_valid, stall, out_valid, out_err;
    logic [W-1:0]  in_data, out_data;
    logic [1:0]    in_mode;
    logic [3:0]    in_stride;
    logic [MW-1:0] in_mask;
    int n_vec = 0;
    int n_bad = 0;
    int dir_lanes [10][8] = '{
        '{0,1,2,3,4,5,6,7}, '{2,3,0,1,6,7,4,5}, '{0,1,2,3,4,5,6,7}, '{7,6,5,4,3,2,1,0},
        '{1,0,2,3,4,5,6,7}, '{0,1,2,7,4,5,6,3}, '{0,1,2,3,4,5,6,7}, '{7,6,5,4,3,2,1,0},
        '{0,1,2,3,4,5,6,7}, '{4,5,6,7,0,1,2,3}};
    logic [1:0]    dir_mode   [10] = '{SW_PASS, SW_STRIDE, SW_STRIDE, SW_REVERSE, SW_MASK,
                                      SW_MASK, SW_PASS, SW_REVERSE, SW_STRIDE, SW_STRIDE};
    logic [3:0]    dir_stride [10] = '{0, 1, 3, 0, 0, 0, 2, 9, 15, 2};
    logic [MW-1:0] dir_mask   [10] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h001,
                                      12'h800, 12'hfff, 12'h000, 12'h000, 12'h5a5};
    logic          dir_err    [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

    perm_switch_net #(.DATA_WIDTH(DW), .N_PORTS(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode),
        .in_stride(in_stride), .in_mask(in_mask), .stall(stall),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data = '0;
        in_mode = SW_PASS;
        in_stride = '0;
        in_mask = '0;
    endtask

    function automatic logic [W-1:0] ident();
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(k);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic logic [W-1:0] ref_perm(input logic [1:0] mode, input logic [3:0] stride,
                                              input logic [MW-1:0] mask, input logic [W-1:0] d,
                                              output logic err);
        logic [DW-1:0] a [N];
        logic [DW-1:0] b [N];
        logic [DW-1:0] t;
        logic [W-1:0]  r;
        for (int i = 0; i < N; i++) a[i] = d[i*DW +: DW];
        b = a;
        err = 1'b0;
        if (mode == SW_STRIDE) begin
            if (int'(stride) >= LOG2N) err = 1'b1;
            else for (int i = 0; i < N; i++) b[i] = a[i ^ (1 << int'(stride))];
        end else if (mode == SW_REVERSE) begin
            for (int i = 0; i < N; i++) b[i] = a[N-1-i];
        end else if (mode == SW_MASK) begin
            for (int s = 0; s < LOG2N; s++)
                for (int p = 0; p < HALF; p++) begin
                    int lo;
                    int hi;
                    lo = sw_pair_lo(p, s);
                    hi = lo + (1 << s);
                    if (mask[s*HALF+p]) begin
                        t = b[lo];
                        b[lo] = b[hi];
                        b[hi] = t;
                    end
                end
        end
        for (int i = 0; i < N; i++) r[i*DW +: DW] = b[i];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b1;
        in_valid = 1'b1;
        in_data = rand_data();
        in_mode = SW_REVERSE;
        in_stride = '0;
        in_mask = '0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", out_data); end
        n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", out_err); end
        rst = 1'b0;
        stall = 1'b0;
        idle();
        repeat (5) tick();
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_directed();
        logic [W-1:0] e;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < N; k++) e[k*DW +: DW] = DW'(dir_lanes[c][k]);
            in_valid = 1'b1;
            in_data = ident();
            in_mode = dir_mode[c];
            in_stride = dir_stride[c];
            in_mask = dir_mask[c];
            tick();
            idle();
            tick();
            tick();
            n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_early: got %b want 0", c, out_valid); end
            tick();
            n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir%0d_valid: got %b want 1", c, out_valid); end
            n_vec++; if (out_data !== e) begin n_bad++; $display("FAIL dir%0d_data: got %h want %h", c, out_data, e); end
            n_vec++; if (out_err !== dir_err[c]) begin n_bad++; $display("FAIL dir%0d_err: got %b want %b", c, out_err, dir_err[c]); end
            tick();
            n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_single: got %b want 0", c, out_valid); end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] vd [4];
        logic [W-1:0] ve [3];
        logic         ee [3];
        logic [1:0]   vm [4] = '{SW_REVERSE, SW_STRIDE, SW_MASK, SW_STRIDE};
        logic [3:0]   vs [4] = '{0, 1, 0, 0};
        logic [MW-1:0] vk [4];
        int           src [10] = '{-1, -1, -1, 0, 0, 0, 1, 2, -1, -1};
        for (int i = 0; i < 4; i++) begin
            vd[i] = rand_data();
            vk[i] = MW'($urandom);
        end
        for (int i = 0; i < 3; i++) ve[i] = ref_perm(vm[i], vs[i], vk[i], vd[i], ee[i]);
        for (int c = 0; c < 10; c++) begin
            if (c < 3 || c == 4 || c == 5) begin
                int v;
                v = (c < 3) ? c : 3;
                in_valid = 1'b1;
                in_data = vd[v];
                in_mode = vm[v];
                in_stride = vs[v];
                in_mask = vk[v];
            end else idle();
            stall = (c == 4 || c == 5);
            tick();
            if (src[c] < 0) begin
                n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_c%0d_valid: got %b want 0", c, out_valid); end
            end else begin
                n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_c%0d_valid: got %b want 1", c, out_valid); end
                n_vec++; if (out_data !== ve[src[c]]) begin n_bad++; $display("FAIL stall_c%0d_data: got %h want %h", c, out_data, ve[src[c]]); end
                n_vec++; if (out_err !== ee[src[c]]) begin n_bad++; $display("FAIL stall_c%0d_err: got %b want %b", c, out_err, ee[src[c]]); end
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] d, e;
        logic         ex;
        in_valid = 1'b1;
        in_data = rand_data();
        in_mode = SW_REVERSE;
        tick();
        idle();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_c%0d_valid: got %b want 0", c, out_valid); end
            n_vec++; if (out_data !== '0) begin n_bad++; $display("FAIL rstmid_c%0d_data: got %h want 0", c, out_data); end
            tick();
        end
        d = rand_data();
        e = ref_perm(SW_STRIDE, 4'd2, '0, d, ex);
        in_valid = 1'b1;
        in_data = d;
        in_mode = SW_STRIDE;
        in_stride = 4'd2;
        tick();
        idle();
        tick();
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_early: got %b want 0", out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== e) begin n_bad++; $display("FAIL rstmid_data: got %h want %h", out_data, e); end
        n_vec++; if (out_err !== ex) begin n_bad++; $display("FAIL rstmid_err: got %b want %b", out_err, ex); end
        repeat (5) tick();
    endtask

    task automatic test_random_stream();
        pend_t        pend [$];
        pend_t        nw;
        logic         exp_v = 1'b0;
        logic [W-1:0] exp_d = '0;
        logic         exp_e = 1'b0;
        logic         stl, acc;
        for (int i = 0; i < 408; i++) begin
            if (i < 400) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data = rand_data();
                in_mode = 2'($urandom);
                in_stride = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
                in_mask = MW'($urandom);
                stall = ($urandom_range(0, 4) == 0);
            end else begin
                idle();
                stall = 1'b0;
            end
            stl = stall;
            acc = in_valid && !stall;
            nw.d = ref_perm(in_mode, in_stride, in_mask, in_data, nw.e);
            nw.left = 3;
            tick();
            if (!stl) begin
                exp_v = 1'b0;
                foreach (pend[j]) pend[j].left--;
                if (pend.size() > 0 && pend[0].left == 0) begin
                    exp_v = 1'b1;
                    exp_d = pend[0].d;
                    exp_e = pend[0].e;
                    void'(pend.pop_front());
                end
                if (acc) pend.push_back(nw);
            end
            n_vec++; if (out_valid !== exp_v) begin n_bad++; $display("FAIL rnd%0d_valid: got %b want %b", i, out_valid, exp_v); end
            if (exp_v) begin
                n_vec++; if (out_data !== exp_d) begin n_bad++; $display("FAIL rnd%0d_data: got %h want %h", i, out_data, exp_d); end
                n_vec++; if (out_err !== exp_e) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", i, out_err, exp_e); end
            end
        end
        n_vec++; if (pend.size() != 0) begin n_bad++; $display("FAIL rnd_drain: got %0d pending want 0", pend.size()); end
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        idle();
        test_reset();
        test_directed();
        test_stall();
        test_reset_midflight();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
